// File: rtl/audio_radius_if.sv
// Audio-to-renderer bundle: PCM sample strobe, frame timing and mute in;
// quantised radius offset, beat pulse and envelope out.
interface audio_radius_if #(
  parameter int unsigned SAMPLE_W = 16
);
  logic signed [SAMPLE_W-1:0] i_sample;
  logic                       i_sample_valid;
  logic                       i_frame_start;
  logic                       i_mute;
  logic [4:0]                 o_radius_off;
  logic                       o_beat;
  logic [SAMPLE_W-2:0]        o_env;

  modport master (
    output i_sample, i_sample_valid, i_frame_start, i_mute,
    input  o_radius_off, o_beat, o_env
  );

  modport slave (
    input  i_sample, i_sample_valid, i_frame_start, i_mute,
    output o_radius_off, o_beat, o_env
  );
endinterface

// File: rtl/audio_radius_driver.sv
// Peak envelope follower (instant attack, timed decay) feeding a 5-bit radius
// offset that only moves at frame start, with a beat pulse on large rises.
module audio_radius_driver #(
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned DECAY_DIV   = 1024,
  parameter int unsigned DECAY_SHIFT = 6,
  parameter int unsigned OFF_SHIFT   = 10,
  parameter int unsigned BEAT_THRESH = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  audio_radius_if.slave  bus
);

  localparam int unsigned EW    = SAMPLE_W - 1;
  localparam int unsigned CNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_DIV - 1);
  localparam logic [5:0] BEAT_T = 6'(BEAT_THRESH);

  logic [EW-1:0]    r_mag;
  logic             r_mag_v;
  logic [EW-1:0]    r_env;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_radius;
  logic             r_beat;

  logic [SAMPLE_W-1:0] w_sample_u;
  logic [SAMPLE_W-1:0] w_abs;
  logic [EW-1:0]       w_mag;
  logic                w_tick;
  logic [EW-1:0]       w_step_raw;
  logic [EW-1:0]       w_step;
  logic [EW-1:0]       w_env_dec;
  logic [EW-1:0]       w_env_shr;
  logic [4:0]          w_tgt;
  logic [5:0]          w_rise;

  // The only magnitude that overflows EW bits is the most negative sample.
  assign w_sample_u = $unsigned(bus.i_sample);
  assign w_abs      = w_sample_u[SAMPLE_W-1] ? (~w_sample_u + {{(SAMPLE_W-1){1'b0}}, 1'b1})
                                             : w_sample_u;
  assign w_mag      = w_abs[SAMPLE_W-1] ? {EW{1'b1}} : w_abs[EW-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mag   <= '0;
      r_mag_v <= 1'b0;
    end else begin
      r_mag_v <= bus.i_sample_valid;
      if (bus.i_sample_valid) begin
        r_mag <= w_mag;
      end
    end
  end

  assign w_tick = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Proportional decay, but never a zero step so small envelopes still reach 0.
  assign w_step_raw = r_env >> DECAY_SHIFT;
  assign w_step     = (w_step_raw == '0) ? {{(EW-1){1'b0}}, 1'b1} : w_step_raw;
  assign w_env_dec  = r_env - w_step;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_env <= '0;
    end else if (bus.i_mute) begin
      r_env <= '0;
    end else if (r_mag_v && (r_mag > r_env)) begin
      r_env <= r_mag;
    end else if (w_tick && (r_env != '0)) begin
      r_env <= w_env_dec;
    end
  end

  assign w_env_shr = r_env >> OFF_SHIFT;

  always_comb begin
    w_tgt = '0;
    if (!bus.i_mute) begin
      w_tgt = (w_env_shr > EW'(31)) ? 5'd31 : w_env_shr[4:0];
    end
  end

  assign w_rise = {1'b0, w_tgt} - {1'b0, r_radius};

  // Rise is immediate, fall is slew-limited to one step per frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_radius <= '0;
      r_beat   <= 1'b0;
    end else begin
      r_beat <= 1'b0;
      if (bus.i_frame_start) begin
        if (bus.i_mute) begin
          r_radius <= '0;
        end else if (w_tgt >= r_radius) begin
          r_radius <= w_tgt;
          r_beat   <= (w_rise >= BEAT_T);
        end else begin
          r_radius <= r_radius - 5'd1;
        end
      end
    end
  end

  assign bus.o_radius_off = r_radius;
  assign bus.o_beat       = r_beat;
  assign bus.o_env        = r_env;

endmodule

// File: doc/audio_radius_driver.md
Name: audio_radius_driver

Overview:
Converts the incoming PCM audio stream into the 5-bit bubble radius offset consumed by the bubble renderer's i_radius_off input. It tracks a peak envelope with instant attack and timed decay, and quantises that envelope to a target level. The output is updated only at VGA frame start, so the radius never changes mid-frame. It sits between the audio codec sample interface and the bubble renderer.

Parameters:
SAMPLE_W, 16, width of signed two's-complement input sample
DECAY_DIV, 1024, clock cycles between envelope decay ticks (>=2)
DECAY_SHIFT, 6, decay step = env >> DECAY_SHIFT (min 1 when env != 0)
OFF_SHIFT, 10, target level = env >> OFF_SHIFT, saturated to 31
BEAT_THRESH, 8, minimum per-frame rise of the output that raises o_beat

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset
i_sample  input  SAMPLE_W  signed PCM sample
i_sample_valid  input  1  sample strobe; no backpressure, every strobed sample is consumed
i_frame_start  input  1  one-cycle pulse at VGA frame start (X=0, Y=0)
i_mute  input  1  level-sensitive mute
o_radius_off  output  5  radius offset to the renderer; changes only on i_frame_start
o_beat  output  1  one-cycle pulse on a large rise of o_radius_off
o_env  output  SAMPLE_W-1  current envelope, for debug and LEDs

Behaviour:
- Reset: i_rst is asynchronous and active-high; the clock is i_clk. Reset clears every register. o_radius_off=0, o_beat=0, o_env=0, decay counter=0. Reset asserted mid-stream discards the in-flight sample.
- Stage 1, magnitude:
  - On an edge where i_sample_valid=1, register mag_r = |i_sample| and set mag_v=1; otherwise mag_v=0.
  - The most negative input (0x8000) saturates to 2^(SAMPLE_W-1)-1 (32767).
- Stage 2, envelope (env_r, SAMPLE_W-1 bits). Priority order:
  1. i_mute=1: env_r <= 0. The decay counter keeps running.
  2. mag_v=1 and mag_r > env_r: env_r <= mag_r (attack).
  3. Decay tick: env_r <= env_r - max(env_r >> DECAY_SHIFT, 1) when env_r != 0; otherwise env_r holds 0.
  4. Otherwise env_r holds.
- Attack beats decay on the same edge. A sample with mag_r <= env_r on a decay-tick edge still decays.
- Decay counter counts 0..DECAY_DIV-1 and wraps. A decay tick occurs on the edge where the counter equals DECAY_DIV-1.
- Latency: a sample strobed at edge N is in mag_r after N. It is reflected in env_r after edge N+1. It is visible on o_radius_off only via an i_frame_start sampled at edge N+2 or later.
- Target: tgt = min(env_r >> OFF_SHIFT, 31), combinational from registered env_r. tgt=0 while i_mute=1 or env_r=0.
- Frame update, on an edge with i_frame_start=1:
  - If tgt >= o_radius_off: o_radius_off <= tgt (instant rise).
  - Else: o_radius_off <= o_radius_off - 1 (fall limited to 1 per frame).
  - Exception: i_mute=1 forces o_radius_off <= 0 immediately.
- o_beat is 1 for exactly the cycle after a frame update where tgt - o_radius_off(old) >= BEAT_THRESH; otherwise 0. Mute never raises o_beat.
- Without i_frame_start, o_radius_off holds indefinitely regardless of envelope activity.
- i_frame_start together with i_sample_valid on the same edge: both are processed. The frame update uses the pre-edge env_r.
- o_env = env_r.

Test Plan:
- Reset: assert i_rst mid-stream with env=20000 -> o_env=0, o_radius_off=0, o_beat=0 asynchronously. After release, the first frame_start gives o_radius_off=0.
- Attack and quantise: sample 0x4000, wait 2 clk, frame_start -> o_env=16384, o_radius_off=16, o_beat pulses once (16-0>=8). Sample 0xEC00 (-5120) on a fresh reset -> level 5, no beat.
- Saturation: sample 0x8000 -> o_env=32767, o_radius_off=31 at next frame_start.
- Decay (DECAY_DIV=4): env=1024 -> 1008 after one tick. env=40 -> 39 (min step 1). env=1 -> 0, then stays 0.
- Slew and hold: o_radius_off=20, env driven to 0, frame_start x3 -> 19, 18, 17. With no frame_start for 10000 cycles the output is unchanged at 17.
- Mute and collisions: i_mute=1 with o_radius_off=25 plus frame_start -> 0 next edge, o_beat=0. Sample valid on a decay-tick edge with mag>env -> env=mag (attack wins).
